keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 119 +++++++++++
 tb/tb_keypad_scanner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Keypad front end for the Raiden game: scans a 4x4 active-low matrix, debounces
// whole scan frames, and turns the debounced key vector into ship position and fire.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned DEB_FRAMES = 3,
    parameter int unsigned LEFT_KEY   = 4,
    parameter int unsigned RIGHT_KEY  = 6,
    parameter int unsigned FIRE_KEY   = 5,
    parameter int unsigned POS_INIT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  keypadRow,
    input  logic [3:0]  keypadCol,
    output logic [2:0]  playerPos,
    output logic        fire,
    output logic [15:0] keys
);

    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam int unsigned StW  = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;

    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);
    localparam logic [StW-1:0]  DebMax = StW'(DEB_FRAMES - 1);

    localparam logic [0:0] StDrive  = 1'b0;
    localparam logic [0:0] StSample = 1'b1;

    localparam logic [2:0] PosMin = 3'd1;
    localparam logic [2:0] PosMax = 3'd6;

    logic [1:0]      row_q, row_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [15:0]     frame_q, frame_d;
    logic [15:0]     prev_q, prev_d;
    logic [StW-1:0]  stable_q, stable_d;
    logic [15:0]     keys_q, keys_d;
    logic            left_dly_q, right_dly_q;
    logic            fire_q, fire_d;
    logic [2:0]      pos_q, pos_d;
    logic [0:0]      scan_state;
    logic            left_rise, right_rise;

    // The sample cycle is the last divider count of each row.
    assign scan_state = (cnt_q == CntMax) ? StSample : StDrive;

    // Row walking, frame accumulation and frame-level debounce.
    always_comb begin
        row_d    = row_q;
        cnt_d    = cnt_q + CntW'(1);
        frame_d  = frame_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        keys_d   = keys_q;
        if (scan_state == StSample) begin
            cnt_d = '0;
            row_d = row_q + 2'd1;
            frame_d[{row_q, 2'b00} +: 4] = ~keypadCol;
            // Row 3 closes the frame; frame_d already holds the row-3 nibble.
            if (row_q == 2'd3) begin
                prev_d = frame_d;
                if (frame_d == prev_q) begin
                    stable_d = (stable_q == DebMax) ? stable_q : stable_q + StW'(1);
                end else begin
                    stable_d = '0;
                end
                if (stable_d == DebMax) begin
                    keys_d = frame_d;
                end
            end
        end
    end

    // Controls react to committed key edges one clock after the commit.
    always_comb begin
        left_rise  = keys_q[LEFT_KEY] & ~left_dly_q;
        right_rise = keys_q[RIGHT_KEY] & ~right_dly_q;
        fire_d     = keys_q[FIRE_KEY];
        pos_d      = pos_q;
        if (left_rise && !right_rise && (pos_q > PosMin)) begin
            pos_d = pos_q - 3'd1;
        end else if (right_rise && !left_rise && (pos_q < PosMax)) begin
            pos_d = pos_q + 3'd1;
        end
    end

    // State registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q       <= 2'd0;
            cnt_q       <= '0;
            frame_q     <= '0;
            prev_q      <= '0;
            stable_q    <= '0;
            keys_q      <= '0;
            left_dly_q  <= 1'b0;
            right_dly_q <= 1'b0;
            fire_q      <= 1'b0;
            pos_q       <= 3'(POS_INIT);
        end else begin
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            keys_q      <= keys_d;
            left_dly_q  <= keys_q[LEFT_KEY];
            right_dly_q <= keys_q[RIGHT_KEY];
            fire_q      <= fire_d;
            pos_q       <= pos_d;
        end
    end

    assign keypadRow = ~(4'b0001 << row_q);
    assign playerPos = pos_q;
    assign fire      = fire_q;
    assign keys      = keys_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical key-matrix model drives the columns and a
// frame-level reference model predicts debounced keys, position and fire.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEB      = 3;
    localparam int unsigned LK       = 4;
    localparam int unsigned RK       = 6;
    localparam int unsigned FK       = 5;
    localparam int unsigned POS_INIT = 3;
    localparam int unsigned FRAME    = 4 * SCAN_DIV;

    localparam logic [15:0] K4 = 16'h0010;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K6 = 16'h0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  keypadRow;
    logic [3:0]  keypadCol;
    logic [2:0]  playerPos;
    logic        fire;
    logic [15:0] keys;
    logic [15:0] pressed = '0;

    int checks = 0;
    int errors = 0;

    logic [15:0] hist[$];
    logic [15:0] m_keys;
    int          m_pos;

    keypad_scanner #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_FRAMES(DEB),
        .LEFT_KEY  (LK),
        .RIGHT_KEY (RK),
        .FIRE_KEY  (FK),
        .POS_INIT  (POS_INIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .keypadRow(keypadRow),
        .keypadCol(keypadCol),
        .playerPos(playerPos),
        .fire     (fire),
        .keys     (keys)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its column low while its row is driven low.
    always_comb begin
        keypadCol = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!keypadRow[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (pressed[r*4+c]) keypadCol[c] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        hist.push_back(16'h0000);  // register contents before the first frame
        m_keys = '0;
        m_pos  = POS_INIT;
    endtask

    // A frame value is accepted once the last DEB frames are identical.
    task automatic model_frame(input logic [15:0] p);
        bit all_same;
        bit l_up;
        bit r_up;
        hist.push_back(p);
        while (hist.size() > DEB) void'(hist.pop_front());
        all_same = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] != p) all_same = 0;
        if (all_same) begin
            l_up = p[LK] && !m_keys[LK];
            r_up = p[RK] && !m_keys[RK];
            if (l_up && !r_up) m_pos = (m_pos - 1 < 1) ? 1 : m_pos - 1;
            if (r_up && !l_up) m_pos = (m_pos + 1 > 6) ? 6 : m_pos + 1;
            m_keys = p;
        end
    endtask

    // Called 1 time unit after the first clock edge of a frame; returns at the same phase.
    task automatic run_frame(input logic [15:0] p);
        logic [3:0] exp_row;
        int         old_pos;
        logic       old_fire;
        pressed = p;
        for (int j = 1; j <= 15; j++) begin
            @(posedge clk);
            #1;
            exp_row = ~(4'b0001 << (((1 + j) % FRAME) / SCAN_DIV));
            chk("row", 16'(keypadRow), 16'(exp_row));
        end
        old_pos  = m_pos;
        old_fire = m_keys[FK];
        model_frame(p);
        chk("keys", keys, m_keys);
        chk("pos_before", 16'(playerPos), 16'(old_pos));
        chk("fire_before", 16'(fire), 16'(old_fire));
        @(posedge clk);
        #1;
        chk("pos", 16'(playerPos), 16'(m_pos));
        chk("fire", 16'(fire), 16'(m_keys[FK]));
        chk("pos_range", 16'(playerPos >= 3'd1 && playerPos <= 3'd6), 16'd1);
    endtask

    // Reset lands between clock edges; outputs must clear with no edge.
    task automatic do_reset();
        #2;
        rst     = 1'b0;
        pressed = '0;
        #1;
        chk("rst_row", 16'(keypadRow), 16'h000E);
        chk("rst_pos", 16'(playerPos), 16'(POS_INIT));
        chk("rst_fire", 16'(fire), 16'd0);
        chk("rst_keys", keys, 16'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] pat;
        int          len;

        // Idle keypad
        do_reset();
        for (int i = 0; i < 3; i++) run_frame('0);

        // Right key held from reset
        do_reset();
        for (int i = 0; i < 4; i++) run_frame(K6);
        chk("t2_pos", 16'(playerPos), 16'd4);

        // Left presses saturate at row 1
        do_reset();
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 4; i++) run_frame(K4);
            for (int i = 0; i < 4; i++) run_frame('0);
        end
        chk("t3_floor", 16'(playerPos), 16'd1);

        // Fire is a level, position untouched
        do_reset();
        for (int i = 0; i < 5; i++) run_frame(K5);
        for (int i = 0; i < 4; i++) run_frame('0);
        chk("t4_pos", 16'(playerPos), 16'd3);

        // Bouncing right key, then steady hold, then climb to the ceiling
        do_reset();
        for (int i = 0; i < 10; i++) run_frame((i % 2 == 0) ? K6 : 16'h0000);
        chk("t5_bounce_keys", keys, 16'd0);
        chk("t5_bounce_pos", 16'(playerPos), 16'd3);
        for (int i = 0; i < 4; i++) run_frame(K6);
        chk("t5_one_step", 16'(playerPos), 16'd4);
        for (int i = 0; i < 3; i++) run_frame('0);
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 3; i++) run_frame(K6);
            for (int i = 0; i < 3; i++) run_frame('0);
        end
        chk("t5_ceiling", 16'(playerPos), 16'd6);

        // Simultaneous left+right, then reset mid-frame
        do_reset();
        for (int i = 0; i < 4; i++) run_frame(K4 | K6);
        chk("t6_both_keys", keys, 16'h0050);
        chk("t6_pos", 16'(playerPos), 16'd3);
        pressed = K6;
        repeat (7) @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 2; i++) run_frame(K6);
        for (int i = 0; i < 3; i++) run_frame('0);
        chk("t6_discard_keys", keys, 16'd0);
        chk("t6_discard_pos", 16'(playerPos), 16'd3);

        // Randomised runs of patterns including multi-key and arbitrary vectors
        do_reset();
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 5))
                0:       pat = '0;
                1:       pat = K4;
                2:       pat = K5;
                3:       pat = K6;
                4:       pat = K4 | K6;
                default: pat = 16'($urandom);
            endcase
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) run_frame(pat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
